// File: rtl/register_scheduler_pkg.sv
// Shared widths, FSM state type and helpers for the register write scheduler.
// Optional SCOREBOARD_BYPASS_EN lets a clearing busy bit stop stalling its reader.
package register_scheduler_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int DATA_W           = 32;
    localparam int NUM_REGS         = 32;
    localparam int STARVE_LIMIT_DEF = 3;

    typedef enum logic {
        IDLE,
        HOLD
    } sched_state_e;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;
    typedef logic [NUM_REGS-1:0]   reg_vec_t;

    // r0 is hardwired, so it never appears in a one-hot register mask
    function automatic reg_vec_t rd_onehot(input reg_addr_t rd, input logic en);
        reg_vec_t v;
        v = '0;
        if (en && rd != '0) begin
            v[rd] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/register_write_scheduler_if.sv
// MDU result channel: valid/ready handshake carrying destination and data.
// The MDU is the master; the write scheduler is the slave.
interface register_write_scheduler_if;
    import register_scheduler_pkg::*;

    logic      mdu_valid;
    reg_addr_t mdu_rd;
    reg_data_t mdu_data;
    logic      mdu_ready;

    modport master (
        output mdu_valid,
        output mdu_rd,
        output mdu_data,
        input  mdu_ready
    );

    modport slave (
        input  mdu_valid,
        input  mdu_rd,
        input  mdu_data,
        output mdu_ready
    );

endinterface

// File: rtl/register_scoreboard.sv
// Busy bits for long-latency destinations plus RAW/WAW/starvation stall.
// With SCOREBOARD_BYPASS_EN a source being cleared this cycle does not stall.
module register_scoreboard
    import register_scheduler_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    input  logic      issue_long,
    input  reg_addr_t rs_a,
    input  reg_addr_t rs_b,
    input  logic      clr_en,
    input  reg_addr_t clr_rd,
    input  logic      starve,
    output logic      stall
);

    reg_vec_t busy_q;
    reg_vec_t set_vec;
    reg_vec_t clr_vec;
    reg_vec_t src_vec;
    reg_vec_t busy_nxt;
    logic     raw_hz;
    logic     waw_hz;

    assign clr_vec = rd_onehot(clr_rd, clr_en);
    assign set_vec = rd_onehot(issue_rd,
                               issue_valid & issue_long & ~stall);

`ifdef SCOREBOARD_BYPASS_EN
    assign src_vec = busy_q & ~clr_vec;
`else
    assign src_vec = busy_q;
`endif

    assign raw_hz = src_vec[rs_a] | src_vec[rs_b];
    assign waw_hz = issue_valid & issue_long & busy_q[issue_rd];
    assign stall  = raw_hz | waw_hz | starve;

    // set after clear so a same-edge set of the same register wins
    always_comb begin
        busy_nxt    = (busy_q & ~clr_vec) | set_vec;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

endmodule

// File: rtl/register_write_scheduler.sv
// Arbitrates pipeline writeback and MDU results onto one registered bank port.
// SCOREBOARD_BYPASS_EN (optional) is consumed by register_scoreboard.
module register_write_scheduler
    import register_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    input  logic      issue_long,
    input  reg_addr_t rs_a,
    input  reg_addr_t rs_b,
    output logic      stall,
    input  logic      wb_valid,
    input  reg_addr_t wb_rd,
    input  reg_data_t wb_data,
    register_write_scheduler_if.slave mdu,
    output logic      reg_write,
    output reg_addr_t rw,
    output reg_data_t busw
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    sched_state_e     state_q;
    reg_addr_t        buf_rd_q;
    reg_data_t        buf_data_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             reg_write_q;
    reg_addr_t        rw_q;
    reg_data_t        busw_q;

    logic      idle;
    logic      mdu_take;
    logic      sel;
    reg_addr_t sel_rd;
    reg_data_t sel_data;
    logic      clr_en;
    logic      starve;
    logic      we_nxt;

    assign idle          = (state_q == IDLE);
    assign mdu.mdu_ready = idle;
    assign mdu_take      = idle & mdu.mdu_valid;
    assign starve        = (hold_cnt_q >= CNT_MAX);

    assign reg_write = reg_write_q;
    assign rw        = rw_q;
    assign busw      = busw_q;

    // writeback always wins; the MDU only gets a free port slot
    always_comb begin
        sel      = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        clr_en   = 1'b0;
        unique case (1'b1)
            wb_valid: begin
                sel      = 1'b1;
                sel_rd   = wb_rd;
                sel_data = wb_data;
            end
            (!wb_valid && mdu_take): begin
                sel      = 1'b1;
                sel_rd   = mdu.mdu_rd;
                sel_data = mdu.mdu_data;
                clr_en   = 1'b1;
            end
            (!wb_valid && !idle): begin
                sel      = 1'b1;
                sel_rd   = buf_rd_q;
                sel_data = buf_data_q;
                clr_en   = 1'b1;
            end
            default: begin
                sel = 1'b0;
            end
        endcase
    end

    assign we_nxt = sel & (sel_rd != '0);

    register_scoreboard u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_long  (issue_long),
        .rs_a        (rs_a),
        .rs_b        (rs_b),
        .clr_en      (clr_en),
        .clr_rd      (sel_rd),
        .starve      (starve),
        .stall       (stall)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_rd_q    <= '0;
            buf_data_q  <= '0;
            hold_cnt_q  <= '0;
            reg_write_q <= 1'b0;
            rw_q        <= '0;
            busw_q      <= '0;
        end else begin
            reg_write_q <= we_nxt;
            rw_q        <= we_nxt ? sel_rd : '0;
            busw_q      <= we_nxt ? sel_data : '0;
            case (state_q)
                IDLE: begin
                    hold_cnt_q <= '0;
                    // an r0 result is dropped instead of being buffered
                    if (mdu.mdu_valid && wb_valid &&
                        mdu.mdu_rd != '0) begin
                        state_q    <= HOLD;
                        buf_rd_q   <= mdu.mdu_rd;
                        buf_data_q <= mdu.mdu_data;
                    end
                end
                HOLD: begin
                    if (!wb_valid) begin
                        state_q    <= IDLE;
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q < CNT_MAX) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    hold_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_write_scheduler.sv
// Directed bench for register_write_scheduler: arbitration, HOLD starvation,
// scoreboard hazards, r0 drops and reset during HOLD.
module tb_register_write_scheduler;
    import register_scheduler_pkg::*;

    logic      clock;
    logic      reset;
    logic      issue_valid;
    reg_addr_t issue_rd;
    logic      issue_long;
    reg_addr_t rs_a;
    reg_addr_t rs_b;
    logic      stall;
    logic      wb_valid;
    reg_addr_t wb_rd;
    reg_data_t wb_data;
    logic      reg_write;
    reg_addr_t rw;
    reg_data_t busw;

    int checks = 0;
    int errors = 0;

    register_write_scheduler_if mdu_if ();

    register_write_scheduler #(.STARVE_LIMIT(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_long  (issue_long),
        .rs_a        (rs_a),
        .rs_b        (rs_b),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mdu         (mdu_if.slave),
        .reg_write   (reg_write),
        .rw          (rw),
        .busw        (busw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        issue_valid      = 1'b0;
        issue_rd         = '0;
        issue_long       = 1'b0;
        rs_a             = '0;
        rs_b             = '0;
        wb_valid         = 1'b0;
        wb_rd            = '0;
        wb_data          = '0;
        mdu_if.mdu_valid = 1'b0;
        mdu_if.mdu_rd    = '0;
        mdu_if.mdu_data  = '0;
    endtask

    task automatic check_port(input string tag, input logic we,
                              input logic [4:0] r, input logic [31:0] d);
        check({tag, ".we"}, {31'd0, reg_write}, {31'd0, we});
        check({tag, ".rw"}, {27'd0, rw}, {27'd0, r});
        check({tag, ".busw"}, busw, d);
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        #1;
        check_port("rst", 1'b0, 5'd0, 32'h0);
        check("rst.ready", {31'd0, mdu_if.mdu_ready}, 32'd1);
        check("rst.stall", {31'd0, stall}, 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // plain writeback, visible for exactly one cycle
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5;
        tick();
        check_port("wb5", 1'b1, 5'd5, 32'hA5A5);
        quiet();
        tick();
        check_port("wb5.off", 1'b0, 5'd0, 32'h0);

        // MDU collides with writeback, is buffered, then drains
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        mdu_if.mdu_valid = 1'b1; mdu_if.mdu_rd = 5'd7;
        mdu_if.mdu_data = 32'h11;
        #1;
        check("col.ready0", {31'd0, mdu_if.mdu_ready}, 32'd1);
        tick();
        check_port("col.wb3", 1'b1, 5'd3, 32'h33);
        check("col.ready1", {31'd0, mdu_if.mdu_ready}, 32'd0);
        quiet();
        tick();
        check_port("col.r7", 1'b1, 5'd7, 32'h11);
        check("col.ready2", {31'd0, mdu_if.mdu_ready}, 32'd1);
        tick();
        check_port("col.idle", 1'b0, 5'd0, 32'h0);

        // writeback held across HOLD until starvation stall
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        mdu_if.mdu_valid = 1'b1; mdu_if.mdu_rd = 5'd7;
        mdu_if.mdu_data = 32'h22;
        tick();
        mdu_if.mdu_valid = 1'b0;
        check("st.c0", {31'd0, stall}, 32'd0);
        tick();
        check("st.c1", {31'd0, stall}, 32'd0);
        check_port("st.wb4", 1'b1, 5'd4, 32'h44);
        tick();
        check("st.c2", {31'd0, stall}, 32'd0);
        tick();
        check("st.c3", {31'd0, stall}, 32'd1);
        tick();
        check("st.c4", {31'd0, stall}, 32'd1);
        check("st.ready", {31'd0, mdu_if.mdu_ready}, 32'd0);
        quiet();
        #1;
        check("st.pre", {31'd0, stall}, 32'd1);
        tick();
        check_port("st.r7", 1'b1, 5'd7, 32'h22);
        check("st.drop", {31'd0, stall}, 32'd0);
        check("st.ready1", {31'd0, mdu_if.mdu_ready}, 32'd1);

        // long issue to r9 and the RAW/WAW hazards it creates
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
        #1;
        check("sb.iss", {31'd0, stall}, 32'd0);
        tick();
        quiet();
        rs_a = 5'd9;
        #1;
        check("sb.raw", {31'd0, stall}, 32'd1);
        rs_a = 5'd0; rs_b = 5'd9;
        #1;
        check("sb.rawb", {31'd0, stall}, 32'd1);
        rs_b = 5'd0;
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
        #1;
        check("sb.waw", {31'd0, stall}, 32'd1);
        quiet();

        // r0 writes are dropped and leave busy[9] alone
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        tick();
        check_port("r0.wb", 1'b0, 5'd0, 32'h0);
        quiet();
        mdu_if.mdu_valid = 1'b1; mdu_if.mdu_rd = 5'd0;
        mdu_if.mdu_data = 32'hBEEF;
        tick();
        check_port("r0.mdu", 1'b0, 5'd0, 32'h0);
        quiet();
        rs_a = 5'd9;
        #1;
        check("r0.busy9", {31'd0, stall}, 32'd1);
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd0;
        rs_a = 5'd0;
        tick();
        quiet();
        #1;
        check("r0.busy0", {31'd0, stall}, 32'd0);

        // MDU write of r9 releases the reader
        rs_a = 5'd9;
        mdu_if.mdu_valid = 1'b1; mdu_if.mdu_rd = 5'd9;
        mdu_if.mdu_data = 32'h99;
        #1;
`ifdef SCOREBOARD_BYPASS_EN
        check("sb.clr", {31'd0, stall}, 32'd0);
`else
        check("sb.clr", {31'd0, stall}, 32'd1);
`endif
        tick();
        mdu_if.mdu_valid = 1'b0;
        check_port("sb.r9", 1'b1, 5'd9, 32'h99);
        check("sb.after", {31'd0, stall}, 32'd0);
        quiet();

        // reset while an r7 result sits in the buffer
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd12;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h3;
        mdu_if.mdu_valid = 1'b1; mdu_if.mdu_rd = 5'd7;
        mdu_if.mdu_data = 32'h77;
        tick();
        check_port("rh.wb3", 1'b1, 5'd3, 32'h3);
        check("rh.ready", {31'd0, mdu_if.mdu_ready}, 32'd0);
        quiet();
        rs_a = 5'd12;
        #1;
        check("rh.busy12", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        #1;
        check_port("rh.rst", 1'b0, 5'd0, 32'h0);
        check("rh.ready1", {31'd0, mdu_if.mdu_ready}, 32'd1);
        check("rh.stall", {31'd0, stall}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check_port("rh.nor7", 1'b0, 5'd0, 32'h0);
        tick();
        check_port("rh.nor7b", 1'b0, 5'd0, 32'h0);
        check("rh.stall2", {31'd0, stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_write_scheduler.md
REGISTER_WRITE_SCHEDULER -- requirements
Module: register_write_scheduler

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, the number of HOLD cycles before stall is forced.
REQ-002 SHALL have ports, in this order:
- clock  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-high.
REQ-003 SHALL have issue ports:
- issue_valid  in  1  instruction leaving decode.
- issue_rd  in  5  its destination.
- issue_long  in  1  destination is produced by the multicycle unit (MDU).
REQ-004 SHALL have rs_a, rs_b  in  5  decode source addresses, and stall  out  1  freezes decode/issue.
REQ-005 SHALL have wb_valid  in  1, wb_rd  in  5, wb_data  in  32: pipeline writeback, always accepted.
REQ-006 SHALL have MDU ports:
- mdu_valid  in  1, mdu_rd  in  5, mdu_data  in  32: MDU result.
- mdu_ready  out  1: MDU result accepted when high together with mdu_valid.
REQ-007 SHALL have bank write port reg_write  out  1, rw  out  5, busw  out  32, all registered.

Function
REQ-008 SHALL register every write-port output on posedge, so a request sampled at edge n drives reg_write for cycle n+1 and the bank commits on that cycle's negedge.
REQ-009 SHALL give wb priority: with wb_valid=1, the next-cycle write is the wb write.
REQ-010 SHALL use FSM IDLE/HOLD with a one-entry MDU hold buffer; mdu_ready=1 in IDLE and 0 in HOLD.
REQ-011 IDLE: mdu_valid&!wb_valid SHALL launch the MDU write directly; mdu_valid&wb_valid SHALL capture the MDU result into the buffer and go to HOLD.
REQ-012 HOLD: !wb_valid SHALL launch the buffer and return to IDLE; wb_valid SHALL keep HOLD and increment a saturating hold counter, which is cleared on leaving HOLD.
REQ-013 SHALL assert stall while the hold counter >= STARVE_LIMIT, so wb bubbles eventually drain the buffer.
REQ-014 Any write with rd=0 SHALL be dropped (reg_write stays 0) and SHALL NOT touch the scoreboard.
REQ-015 SHALL keep busy[31:1]:
- Set at the edge where issue_valid&issue_long&!stall with issue_rd!=0.
- Cleared at the edge where the MDU write for that rd is launched to the outputs.
- busy[0] SHALL always be 0.
REQ-016 On a simultaneous set and clear of the same register, set SHALL win.
REQ-017 stall SHALL be the OR of:
- busy[rs_a] or busy[rs_b] (RAW hazard);
- issue_valid&issue_long&busy[issue_rd] (WAW hazard);
- the REQ-013 term.
REQ-018 stall SHALL be combinational from current state and inputs.

Reset
REQ-019 While reset=1: state=IDLE, busy=0, hold counter=0, buffer empty, reg_write=0, rw=0, busw=0.
REQ-020 Reset while in HOLD SHALL discard the buffered MDU result.
REQ-021 After reset, mdu_ready=1 and stall=0.

Configuration
REQ-022 With SCOREBOARD_BYPASS_EN defined, a source whose busy bit is being cleared in the current cycle SHALL NOT contribute to stall.
REQ-023 Without SCOREBOARD_BYPASS_EN, stall SHALL persist until the cycle after the clear edge.

Structure
REQ-024 Package register_scheduler_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, the IDLE/HOLD state type and the STARVE_LIMIT default.
REQ-025 The busy vector and hazard logic SHALL be sub-module register_scoreboard; arbitration, buffer and FSM SHALL stay in the top.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- wb_valid, rd=5, data=0xA5A5 at edge 1 -> reg_write=1, rw=5, busw=0xA5A5 in cycle 2 only.
- mdu_valid rd=7 data=0x11 together with wb rd=3 -> cycle+1 writes r3, mdu_ready=0, next free cycle writes r7, then IDLE.
- wb_valid held 5 cycles during HOLD -> stall rises after 3 HOLD cycles and falls when the buffer drains.
- Long issue rd=9, then rs_a=9 -> stall=1 until MDU r9 write; release is same cycle with SCOREBOARD_BYPASS_EN, one cycle later without.
- wb or MDU write to rd=0 -> reg_write stays 0, busy unchanged; issue_long rd=9 while busy[9]=1 -> stall=1.
- reset asserted mid-HOLD -> all outputs 0, busy=0, mdu_ready=1 immediately, buffered r7 never written.
